// File: rtl/jtag_config_bank.sv
// Purpose: JTAG-side bank of NUM_REGS config registers sharing one DR shift chain,
//          with a valid/ack update handshake to the die and a lock with sticky errors.
// Latency: capture/shift/update all take effect on the TCK edge ending the TAP state.
// Backpressure: none on the TAP side; an unacked update followed by another sets cfg_overrun.
//
// Ports:
//   TCK, TRST           test clock, async active-high reset
//   TDI, cfg_tdo        serial chain in / out (LSB first)
//   tap_state, IR       TAP state and current instruction; IR_BASE..IR_BASE+NUM_REGS-1 selects
//   cfg_lock            blocks register updates (capture/shift still work)
//   cfg_upd_ack         consumer acknowledge of the pending update
//   err_clr             clears the sticky flags
//   cfg_flat            all registers, register k at [k*DATA_W +: DATA_W]
//   cfg_upd_valid/idx   pending-update handshake and index of the latest update
//   cfg_overrun         sticky: update landed while the previous one was unacked
//   cfg_lock_err        sticky: update attempted while locked
//   cfg_sel             IR is inside the bank's range
module jtag_config_bank #(
  parameter int              DATA_W   = 8,
  parameter int              NUM_REGS = 4,
  parameter int              IR_W     = 4,
  parameter logic [IR_W-1:0] IR_BASE  = IR_W'(3),
  parameter int              IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       TCK,
  input  logic                       TRST,
  input  logic                       TDI,
  input  logic [3:0]                 tap_state,
  input  logic [IR_W-1:0]            IR,
  input  logic                       cfg_lock,
  input  logic                       cfg_upd_ack,
  input  logic                       err_clr,
  output logic [NUM_REGS*DATA_W-1:0] cfg_flat,
  output logic                       cfg_upd_valid,
  output logic [IDX_W-1:0]           cfg_upd_idx,
  output logic                       cfg_overrun,
  output logic                       cfg_lock_err,
  output logic                       cfg_sel,
  output logic                       cfg_tdo
);

  localparam logic [3:0] CAPTURE_DR = 4'd3;
  localparam logic [3:0] SHIFT_DR   = 4'd4;
  localparam logic [3:0] UPDATE_DR  = 4'd8;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]               shift_q, shift_d;
  logic                            valid_q, valid_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            overrun_q, overrun_d;
  logic                            lock_err_q, lock_err_d;

  logic [IR_W-1:0]  idx_raw;
  logic [IDX_W-1:0] idx;
  logic             upd_fire;
  logic             upd_blocked;
  logic             overrun_set;

  // Subtraction wraps at IR_W bits, so codes below IR_BASE land far out of range.
  assign idx_raw = IR - IR_BASE;
  assign cfg_sel = (32'(idx_raw) < NUM_REGS);
  assign idx     = IDX_W'(idx_raw);

  assign upd_fire    = cfg_sel && (tap_state == UPDATE_DR) && !cfg_lock;
  assign upd_blocked = cfg_sel && (tap_state == UPDATE_DR) &&  cfg_lock;
  // An ack arriving with the new update consumes the old one, so no overrun then.
  assign overrun_set = upd_fire && valid_q && !cfg_upd_ack;

  always_comb begin
    regs_d     = regs_q;
    shift_d    = shift_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    overrun_d  = overrun_q;
    lock_err_d = lock_err_q;

    if (cfg_sel && tap_state == CAPTURE_DR) begin
      shift_d = regs_q[idx];
    end else if (cfg_sel && tap_state == SHIFT_DR) begin
      shift_d = {TDI, shift_q[DATA_W-1:1]};
    end

    if (upd_fire) begin
      regs_d[idx] = shift_q;
      idx_d       = idx;
      valid_d     = 1'b1;
    end else if (cfg_upd_ack) begin
      valid_d = 1'b0;
    end

    // Sticky flags: a set in the same cycle beats err_clr.
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end

    if (upd_blocked) begin
      lock_err_d = 1'b1;
    end else if (err_clr) begin
      lock_err_d = 1'b0;
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      regs_q     <= '0;
      shift_q    <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      overrun_q  <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign cfg_flat      = regs_q;
  assign cfg_upd_valid = valid_q;
  assign cfg_upd_idx   = idx_q;
  assign cfg_overrun   = overrun_q;
  assign cfg_lock_err  = lock_err_q;
  assign cfg_tdo       = shift_q[0];

endmodule

// File: tb/tb_jtag_config_bank.sv
// Purpose: self-checking bench for jtag_config_bank against a behavioural model.
// Latency: model advances once per TCK rising edge; outputs compared on the falling edge.
// Backpressure: n/a (bench drives ack/lock/err_clr directly).
module tb_jtag_config_bank;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int IR_W     = 4;
  localparam int IR_BASE  = 3;
  localparam int IDX_W    = 2;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_CAP  = 4'd3;
  localparam logic [3:0] ST_SHF  = 4'd4;
  localparam logic [3:0] ST_UPD  = 4'd8;

  logic                       TCK = 1'b0;
  logic                       TRST;
  logic                       TDI;
  logic [3:0]                 tap_state;
  logic [IR_W-1:0]            IR;
  logic                       cfg_lock;
  logic                       cfg_upd_ack;
  logic                       err_clr;
  logic [NUM_REGS*DATA_W-1:0] cfg_flat;
  logic                       cfg_upd_valid;
  logic [IDX_W-1:0]           cfg_upd_idx;
  logic                       cfg_overrun;
  logic                       cfg_lock_err;
  logic                       cfg_sel;
  logic                       cfg_tdo;

  jtag_config_bank #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IR_W(IR_W),
    .IR_BASE(IR_W'(IR_BASE)), .IDX_W(IDX_W)
  ) dut (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .tap_state(tap_state), .IR(IR),
    .cfg_lock(cfg_lock), .cfg_upd_ack(cfg_upd_ack), .err_clr(err_clr),
    .cfg_flat(cfg_flat), .cfg_upd_valid(cfg_upd_valid), .cfg_upd_idx(cfg_upd_idx),
    .cfg_overrun(cfg_overrun), .cfg_lock_err(cfg_lock_err), .cfg_sel(cfg_sel),
    .cfg_tdo(cfg_tdo)
  );

  always #5 TCK = ~TCK;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic [DATA_W-1:0] m_shift;
  bit                m_valid;
  int                m_idx;
  bit                m_ovr;
  bit                m_lerr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sel_index(input logic [IR_W-1:0] ir);
    return (int'(ir) - IR_BASE + (1 << IR_W)) % (1 << IR_W);
  endfunction

  function automatic bit in_range(input logic [IR_W-1:0] ir);
    return sel_index(ir) < NUM_REGS;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
    m_shift = '0;
    m_valid = 0;
    m_idx   = 0;
    m_ovr   = 0;
    m_lerr  = 0;
  endtask

  // One rising edge of behaviour, read off the rules in plain terms.
  task automatic model_edge();
    int               k;
    bit               sel;
    bit               new_upd;
    bit               ovr_set;
    bit               lerr_set;
    logic [DATA_W-1:0] old_shift;
    k         = sel_index(IR);
    sel       = in_range(IR);
    old_shift = m_shift;
    new_upd   = 0;
    ovr_set   = 0;
    lerr_set  = 0;
    if (sel && tap_state == ST_CAP) m_shift = m_regs[k];
    if (sel && tap_state == ST_SHF) m_shift = (old_shift >> 1) | (DATA_W'(TDI) << (DATA_W-1));
    if (sel && tap_state == ST_UPD) begin
      if (cfg_lock) lerr_set = 1;
      else begin
        new_upd = 1;
        if (m_valid && !cfg_upd_ack) ovr_set = 1;
        m_regs[k] = old_shift;
        m_idx     = k;
      end
    end
    if (new_upd) m_valid = 1;
    else if (cfg_upd_ack && m_valid) m_valid = 0;
    if (ovr_set) m_ovr = 1;
    else if (err_clr) m_ovr = 0;
    if (lerr_set) m_lerr = 1;
    else if (err_clr) m_lerr = 0;
  endtask

  task automatic check_outputs();
    logic [NUM_REGS*DATA_W-1:0] ef;
    for (int k = 0; k < NUM_REGS; k++) ef[k*DATA_W +: DATA_W] = m_regs[k];
    chk("cfg_flat", cfg_flat, ef);
    chk("valid", cfg_upd_valid, m_valid);
    chk("idx", cfg_upd_idx, m_idx);
    chk("overrun", cfg_overrun, m_ovr);
    chk("lock_err", cfg_lock_err, m_lerr);
    chk("sel", cfg_sel, in_range(IR));
    chk("tdo", cfg_tdo, m_shift[0]);
  endtask

  // Called just after a falling edge: drive, clock, model, compare.
  task automatic step(input logic [3:0] st, input logic [IR_W-1:0] ir, input logic tdi,
                      input logic lock, input logic ack, input logic clr);
    tap_state   = st;
    IR          = ir;
    TDI         = tdi;
    cfg_lock    = lock;
    cfg_upd_ack = ack;
    err_clr     = clr;
    @(posedge TCK);
    if (TRST) model_reset();
    else model_edge();
    @(negedge TCK);
    check_outputs();
  endtask

  task automatic write_reg(input int k, input logic [DATA_W-1:0] val,
                           input logic lock, input logic ack_on_upd);
    logic [IR_W-1:0] ir;
    ir = IR_W'(IR_BASE + k);
    for (int i = 0; i < DATA_W; i++) step(ST_SHF, ir, val[i], lock, 1'b0, 1'b0);
    step(ST_UPD, ir, 1'b0, lock, ack_on_upd, 1'b0);
  endtask

  task automatic readback(input int k, input logic [DATA_W-1:0] exp, input string tag);
    logic [IR_W-1:0] ir;
    ir = IR_W'(IR_BASE + k);
    step(ST_CAP, ir, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      chk(tag, cfg_tdo, exp[i]);
      step(ST_SHF, ir, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic quiesce();
    step(ST_IDLE, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [3:0] st;
    logic [IR_W-1:0] ir;
    TRST = 1'b1; TDI = 1'b0; tap_state = ST_IDLE; IR = '0;
    cfg_lock = 1'b0; cfg_upd_ack = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge TCK);
    TRST = 1'b0;
    check_outputs();
    chk("reset_flat", cfg_flat, 0);

    // Capture reg 2 after reset: zeros out.
    readback(2, 8'h00, "rst_readback");

    // Write A5 into reg 1, ack next cycle, read it back.
    write_reg(1, 8'hA5, 1'b0, 1'b0);
    chk("a5_flat", cfg_flat[15:8], 8'hA5);
    chk("a5_valid", cfg_upd_valid, 1);
    chk("a5_idx", cfg_upd_idx, 1);
    step(ST_IDLE, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5_ack", cfg_upd_valid, 0);
    readback(1, 8'hA5, "a5_readback");

    // Two updates without ack: overrun, latest index wins; err_clr keeps valid.
    write_reg(0, 8'h11, 1'b0, 1'b0);
    write_reg(3, 8'h33, 1'b0, 1'b0);
    chk("ovr_flag", cfg_overrun, 1);
    chk("ovr_idx", cfg_upd_idx, 3);
    chk("ovr_r0", cfg_flat[7:0], 8'h11);
    chk("ovr_r3", cfg_flat[31:24], 8'h33);
    step(ST_IDLE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", cfg_overrun, 0);
    chk("ovr_clr_valid", cfg_upd_valid, 1);

    // Update together with ack while valid: no overrun.
    write_reg(2, 8'h5C, 1'b0, 1'b1);
    chk("ackupd_valid", cfg_upd_valid, 1);
    chk("ackupd_idx", cfg_upd_idx, 2);
    chk("ackupd_ovr", cfg_overrun, 0);
    quiesce();

    // Locked update into reg 0.
    write_reg(0, 8'hFF, 1'b1, 1'b0);
    chk("lock_r0", cfg_flat[7:0], 8'h11);
    chk("lock_err", cfg_lock_err, 1);
    chk("lock_valid", cfg_upd_valid, 0);
    readback(0, 8'h11, "lock_readback");
    quiesce();

    // Out-of-range IR through capture/shift/update.
    step(ST_CAP, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("oor_sel", cfg_sel, 0);
    for (int i = 0; i < DATA_W; i++) step(ST_SHF, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ST_UPD, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("oor_valid", cfg_upd_valid, 0);

    // Reset mid-shift with an update pending.
    write_reg(3, 8'hC3, 1'b0, 1'b0);
    step(ST_CAP, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
    step(ST_SHF, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
    TRST = 1'b1;
    #1;
    chk("trst_flat", cfg_flat, 0);
    chk("trst_valid", cfg_upd_valid, 0);
    chk("trst_tdo", cfg_tdo, 0);
    chk("trst_idx", cfg_upd_idx, 0);
    model_reset();
    @(negedge TCK);
    step(ST_SHF, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
    TRST = 1'b0;
    step(ST_CAP, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1:       st = ST_CAP;
        2, 3, 4, 5: st = ST_SHF;
        6, 7:       st = ST_UPD;
        default:    st = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 9) < 7) ir = IR_W'(IR_BASE + $urandom_range(0, NUM_REGS-1));
      else ir = IR_W'($urandom_range(0, 15));
      step(st, ir, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
